// File: rtl/fetch_sequencer.sv
// Fetch/execute sequencer: owns the PC, latches IR, strobes Execute; two cycles per instruction.
// Jump-to-self parks the machine in HALT until reset; Run/Step are sampled inputs only.
module fetch_sequencer #(
    parameter int                ADDR_W   = 8,
    parameter int                CNT_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              input_Clock,
    input  logic              input_Reset,
    input  logic              input_Run,
    input  logic              input_Step,
    input  logic [7:0]        input_Instruction,
    output logic [ADDR_W-1:0] output_Address,
    output logic [7:0]        output_Instruction,
    output logic              output_Execute,
    output logic              output_Halted,
    output logic [1:0]        output_Phase,
    output logic [CNT_W-1:0]  output_Retired
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [ADDR_W-1:0] PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [CNT_W-1:0]  retired_q, retired_d;
    logic              step_prev_q;

    logic              step_pulse;
    logic              is_jump;
    logic              halt_hit;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] jump_target;

    assign step_pulse  = input_Step & ~step_prev_q;
    assign is_jump     = (ir_q[7:6] == 2'b11);
    assign pc_inc      = pc_q + PC_ONE;
    assign jump_target = pc_inc + {{(ADDR_W-6){ir_q[5]}}, ir_q[5:0]};
    // A jump whose target is its own address is the halt idiom.
    assign halt_hit    = is_jump && (jump_target == pc_q);

    always_ff @(posedge input_Clock) begin
        if (input_Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (input_Run || step_pulse) state_d = S_FETCH;
            S_FETCH: state_d = S_EXEC;
            S_EXEC: begin
                if (halt_hit)       state_d = S_HALT;
                else if (input_Run) state_d = S_FETCH;
                else                state_d = S_IDLE;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_comb begin
        output_Execute = (state_q == S_EXEC);
        output_Halted  = (state_q == S_HALT);
        output_Phase   = state_q;
    end

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        retired_d = retired_q;
        if (state_q == S_FETCH) begin
            ir_d = input_Instruction;
        end
        if (state_q == S_EXEC) begin
            retired_d = (&retired_q) ? retired_q : retired_q + CNT_ONE;
            if (!halt_hit) begin
                pc_d = is_jump ? jump_target : pc_inc;
            end
        end
    end

    // Step history resets high so a Step held through reset is not an edge.
    always_ff @(posedge input_Clock) begin
        if (input_Reset) begin
            pc_q        <= RESET_PC;
            ir_q        <= 8'h00;
            retired_q   <= '0;
            step_prev_q <= 1'b1;
        end else begin
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            retired_q   <= retired_d;
            step_prev_q <= input_Step;
        end
    end

    assign output_Address     = pc_q;
    assign output_Instruction = ir_q;
    assign output_Retired     = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: memory model, execute-event scoreboard and directed phase checks.
module tb_fetch_sequencer;

    logic        clk;
    logic        input_Reset;
    logic        input_Run;
    logic        input_Step;
    logic [7:0]  input_Instruction;
    logic [7:0]  output_Address;
    logic [7:0]  output_Instruction;
    logic        output_Execute;
    logic        output_Halted;
    logic [1:0]  output_Phase;
    logic [15:0] output_Retired;

    logic [7:0]  mem [256];

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  ir;
        logic [15:0] ret;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exec_cnt = 0;
    int   base_cnt;

    fetch_sequencer #(.ADDR_W(8), .CNT_W(16), .RESET_PC(8'h00)) dut (
        .input_Clock        (clk),
        .input_Reset        (input_Reset),
        .input_Run          (input_Run),
        .input_Step         (input_Step),
        .input_Instruction  (input_Instruction),
        .output_Address     (output_Address),
        .output_Instruction (output_Instruction),
        .output_Execute     (output_Execute),
        .output_Halted      (output_Halted),
        .output_Phase       (output_Phase),
        .output_Retired     (output_Retired)
    );

    assign input_Instruction = mem[output_Address];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] i, input logic [15:0] r);
        exp_t e;
        e.addr = a;
        e.ir   = i;
        e.ret  = r;
        sb_q.push_back(e);
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int a = 0; a < 256; a++) mem[a] = v;
    endtask

    // Every Execute strobe must match the next expected (address, IR, retired-before) entry.
    always @(negedge clk) begin
        exp_t e;
        if (output_Execute === 1'b1) begin
            exec_cnt++;
            if (sb_q.size() == 0) begin
                chk("exec_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("exec_addr", 32'(output_Address), 32'(e.addr));
                chk("exec_ir", 32'(output_Instruction), 32'(e.ir));
                chk("exec_retired", 32'(output_Retired), 32'(e.ret));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        input_Reset = 1'b1;
        input_Run   = 1'b1;
        input_Step  = 1'b0;
        fill_mem(8'h01);
        mem[3] = 8'hFF;

        // Free-run to halt
        tick(2);
        chk("rst_phase", 32'(output_Phase), 32'd0);
        chk("rst_addr", 32'(output_Address), 32'h00);
        chk("rst_ir", 32'(output_Instruction), 32'h00);
        chk("rst_exec", 32'(output_Execute), 32'd0);
        chk("rst_halted", 32'(output_Halted), 32'd0);
        chk("rst_retired", 32'(output_Retired), 32'd0);
        push(8'h00, 8'h01, 16'd0);
        push(8'h01, 8'h01, 16'd1);
        push(8'h02, 8'h01, 16'd2);
        push(8'h03, 8'hFF, 16'd3);
        input_Reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            chk("run_exec_slot", 32'(output_Execute), 32'((k == 2) || (k == 4) || (k == 6) || (k == 8)));
            if (k >= 9) begin
                chk("run_halted", 32'(output_Halted), 32'd1);
                chk("run_halt_pc", 32'(output_Address), 32'h03);
                chk("run_halt_retired", 32'(output_Retired), 32'd4);
            end
        end

        // Halt lock against Run/Step activity
        for (int k = 0; k < 20; k++) begin
            input_Run  = 1'($urandom_range(1, 0));
            input_Step = (k % 2 == 0);
            tick(1);
            chk("halt_exec", 32'(output_Execute), 32'd0);
            chk("halt_addr", 32'(output_Address), 32'h03);
            chk("halt_phase", 32'(output_Phase), 32'd3);
        end

        // Single-step, Step held high across reset
        mem[3]      = 8'h01;
        input_Run   = 1'b0;
        input_Step  = 1'b1;
        input_Reset = 1'b1;
        tick(2);
        input_Reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(1);
            chk("step_noedge_phase", 32'(output_Phase), 32'd0);
            chk("step_noedge_addr", 32'(output_Address), 32'h00);
        end
        base_cnt   = exec_cnt;
        input_Step = 1'b0;
        tick(1);
        push(8'h00, 8'h01, 16'd0);
        input_Step = 1'b1;
        tick(10);
        input_Step = 1'b0;
        tick(2);
        chk("step1_count", 32'(exec_cnt - base_cnt), 32'd1);
        chk("step1_addr", 32'(output_Address), 32'h01);
        chk("step1_phase", 32'(output_Phase), 32'd0);
        push(8'h01, 8'h01, 16'd1);
        input_Step = 1'b1;
        tick(3);
        input_Step = 1'b0;
        tick(2);
        chk("step2_count", 32'(exec_cnt - base_cnt), 32'd2);
        chk("step2_addr", 32'(output_Address), 32'h02);

        // Jump arithmetic, PC wrap and Run drop during FETCH
        fill_mem(8'h01);
        mem[8'h01] = 8'hCE;
        mem[8'h10] = 8'hC5;
        mem[8'h16] = 8'hEB;
        mem[8'h02] = 8'hF0;
        mem[8'hF3] = 8'hCB;
        input_Reset = 1'b1;
        input_Run   = 1'b1;
        tick(2);
        push(8'h00, 8'h01, 16'd0);
        push(8'h01, 8'hCE, 16'd1);
        push(8'h10, 8'hC5, 16'd2);
        push(8'h16, 8'hEB, 16'd3);
        push(8'h02, 8'hF0, 16'd4);
        push(8'hF3, 8'hCB, 16'd5);
        push(8'hFF, 8'h01, 16'd6);
        push(8'h00, 8'h01, 16'd7);
        input_Reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            tick(1);
            if (k == 7)  chk("jump_fwd_addr", 32'(output_Address), 32'h16);
            if (k == 11) chk("jump_back_wrap_addr", 32'(output_Address), 32'hF3);
            if (k == 15) begin
                chk("pc_wrap_addr", 32'(output_Address), 32'h00);
                chk("drop_in_fetch", 32'(output_Phase), 32'd1);
                input_Run = 1'b0;
            end
            if (k == 16) chk("drop_exec_done", 32'(output_Execute), 32'd1);
        end
        chk("drop_idle_phase", 32'(output_Phase), 32'd0);
        chk("drop_idle_addr", 32'(output_Address), 32'h01);
        chk("drop_idle_retired", 32'(output_Retired), 32'd8);
        tick(3);
        chk("drop_stays_idle", 32'(output_Phase), 32'd0);

        // Reset during EXEC
        push(8'h01, 8'hCE, 16'd8);
        input_Run = 1'b1;
        tick(2);
        chk("mid_exec_phase", 32'(output_Phase), 32'd2);
        input_Reset = 1'b1;
        input_Run   = 1'b0;
        tick(1);
        chk("mid_rst_phase", 32'(output_Phase), 32'd0);
        chk("mid_rst_addr", 32'(output_Address), 32'h00);
        chk("mid_rst_exec", 32'(output_Execute), 32'd0);
        chk("mid_rst_retired", 32'(output_Retired), 32'd0);
        input_Reset = 1'b0;
        tick(2);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
